// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK_WAIT
  } rx_state_t;

  typedef struct packed {
    logic parity_err;
    logic frame_err;
  } rx_status_t;

  // Clocks per oversample tick, integer-truncated.
  function automatic int calc_div(input int clk_hz, input int baud, input int os);
    return clk_hz / (baud * os);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running prescaler: one-cycle tick every DIV clocks.
module uart_baud_tick #(
  parameter int DIV = 4
) (
  input  logic clk_in,
  input  logic rst_n_in,
  output logic tick_out
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Count 0..DIV-1 and wrap.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)        cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end

  assign tick_out = (cnt == LAST);

endmodule

// File: rtl/uart_rx_core.sv
// UART receive engine with held ready/valid output and error flags.
// Optional macro UART_RX_MAJORITY_EN: 2-of-3 majority vote around mid-bit.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int INPUT_CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE        = 115200,
  parameter int OVERSAMPLE       = 16,
  parameter int DATA_BITS        = 8,
  parameter int PARITY           = 0,
  parameter int STOP_BITS        = 1
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 rx_wire_in,
  input  logic                 data_ready_in,
  output logic                 data_valid_out,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 parity_err_out,
  output logic                 frame_err_out,
  output logic                 overrun_err_out,
  output logic                 break_out
);

  localparam int DIV = calc_div(INPUT_CLOCK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int SCW = $clog2(OVERSAMPLE);
  localparam logic [SCW-1:0] MID  = SCW'(OVERSAMPLE / 2);
  localparam logic [SCW-1:0] LAST = SCW'(OVERSAMPLE - 1);
`ifdef UART_RX_MAJORITY_EN
  localparam logic [SCW-1:0] DEC = SCW'(OVERSAMPLE / 2 + 1);
`else
  localparam logic [SCW-1:0] DEC = MID;
`endif
  localparam parity_t PMODE = parity_t'(PARITY);

  if (DIV < 2 || !(OVERSAMPLE == 8 || OVERSAMPLE == 16) ||
      DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2) begin : g_param_check
    $error("uart_rx_core: illegal parameter combination");
  end

  logic                 tick;
  logic                 sync1, sync2;
  rx_state_t            state, state_nx;
  logic [SCW-1:0]       scnt, scnt_nx;
  logic [3:0]           bidx, bidx_nx;
  logic                 sidx, sidx_nx;
  logic                 frame_flag, frame_nx;
  logic [DATA_BITS-1:0] shreg, shreg_nx;
  logic                 par_bit, par_nx;
  logic                 take, bit_val, exp_par;
  logic                 deliver, brk_evt;
  rx_status_t           status_q, status_nx;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .tick_out (tick)
  );

  // Two-flop synchroniser, idles high.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= rx_wire_in;
      sync2 <= sync1;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic maj0, maj1;

  // Capture the two samples that precede the decision tick.
  always_ff @(posedge clk_in) begin
    if (tick && scnt == MID - 1'b1) maj0 <= sync2;
    if (tick && scnt == MID)        maj1 <= sync2;
  end

  assign bit_val = (maj0 & maj1) | (maj0 & sync2) | (maj1 & sync2);
`else
  assign bit_val = sync2;
`endif

  assign take = tick && (scnt == DEC);

  // FSM control registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state      <= IDLE;
      scnt       <= '0;
      bidx       <= '0;
      sidx       <= 1'b0;
      frame_flag <= 1'b0;
    end else begin
      state      <= state_nx;
      scnt       <= scnt_nx;
      bidx       <= bidx_nx;
      sidx       <= sidx_nx;
      frame_flag <= frame_nx;
    end
  end

  // Datapath registers; content is always rebuilt before it is used.
  always_ff @(posedge clk_in) begin
    shreg   <= shreg_nx;
    par_bit <= par_nx;
  end

  // Next-state, bit sampling and delivery/break decisions.
  always_comb begin
    state_nx  = state;
    scnt_nx   = scnt;
    bidx_nx   = bidx;
    sidx_nx   = sidx;
    frame_nx  = frame_flag;
    shreg_nx  = shreg;
    par_nx    = par_bit;
    deliver   = 1'b0;
    brk_evt   = 1'b0;
    exp_par   = (PMODE == PAR_ODD) ? ~(^shreg) : ^shreg;
    status_nx = '0;
    if (tick && state != IDLE) scnt_nx = (scnt == LAST) ? '0 : scnt + 1'b1;
    case (state)
      IDLE: begin
        if (tick && !sync2) begin
          state_nx = START;
          scnt_nx  = '0;
        end
      end
      START: begin
        if (take) begin
          if (bit_val) state_nx = IDLE;
          else begin
            state_nx = DATA;
            bidx_nx  = '0;
            frame_nx = 1'b0;
          end
        end
      end
      DATA: begin
        if (take) begin
          shreg_nx = {bit_val, shreg[DATA_BITS-1:1]};
          bidx_nx  = bidx + 4'd1;
          if (bidx == 4'(DATA_BITS - 1)) begin
            sidx_nx  = 1'b0;
            state_nx = (PMODE == PAR_NONE) ? STOP : uart_pkg::PARITY;
          end
        end
      end
      uart_pkg::PARITY: begin
        if (take) begin
          par_nx   = bit_val;
          state_nx = STOP;
        end
      end
      STOP: begin
        if (take) begin
          frame_nx = frame_flag | ~bit_val;
          sidx_nx  = sidx + 1'b1;
          if (sidx == 1'(STOP_BITS - 1)) begin
            if (shreg == '0 && (PMODE == PAR_NONE || !par_bit) && frame_nx) begin
              brk_evt  = 1'b1;
              state_nx = BREAK_WAIT;
            end else begin
              deliver  = 1'b1;
              state_nx = IDLE;
            end
          end
        end
      end
      BREAK_WAIT: begin
        if (tick && sync2) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    status_nx.parity_err = (PMODE != PAR_NONE) && (par_bit != exp_par);
    status_nx.frame_err  = frame_nx;
  end

  // Held-output handshake with overrun and break pulses.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      data_valid_out  <= 1'b0;
      data_out        <= '0;
      status_q        <= '0;
      overrun_err_out <= 1'b0;
      break_out       <= 1'b0;
    end else begin
      overrun_err_out <= 1'b0;
      break_out       <= brk_evt;
      if (deliver) begin
        if (data_valid_out && !data_ready_in) begin
          overrun_err_out <= 1'b1;
        end else begin
          data_out       <= shreg;
          status_q       <= status_nx;
          data_valid_out <= 1'b1;
        end
      end else if (data_ready_in) begin
        data_valid_out <= 1'b0;
      end
    end
  end

  assign parity_err_out = status_q.parity_err;
  assign frame_err_out  = status_q.frame_err;

endmodule
